reset_release_sequencer: RTL and testbench

- Consumes the CLK/RST_N pair delivered by the clock/reset bridge.
- Generates NUM_STAGES ordered, per-domain active-low resets for the portal/DMA/user logic.
- After RST_N deasserts: holds all stages in reset for HOLD_CYCLES, then releases them one at a time.
- Each release waits for that stage's ready acknowledge, or a timeout, before the next stage; a software-initiated re-sequence is also supported.

---
 rtl/reset_release_sequencer.sv | 143 ++++++++++++++
 tb/tb_reset_release_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/reset_release_sequencer.sv
// Purpose: releases NUM_STAGES per-domain active-low resets in order after a hold period, with ack/timeout gating.
// Latency: first release HOLD_CYCLES edges after RST_N high; each later release STAGE_GAP edges after the previous ack/timeout.
// Backpressure: a stage that never acks stalls the sequence for ACK_TIMEOUT edges, then it is forced forward and timeout_err is set.
module reset_release_sequencer #(
  parameter int NUM_STAGES  = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 4,
  parameter int ACK_TIMEOUT = 64,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  soft_rst_req,
  input  logic [NUM_STAGES-1:0] stage_ack,
  output logic [NUM_STAGES-1:0] stage_rst_n,
  output logic [2:0]            stage_idx,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout_err
);

  typedef enum logic [1:0] {
    HOLD     = 2'd0,
    WAIT_ACK = 2'd1,
    GAP      = 2'd2,
    DONE     = 2'd3
  } state_t;

  // Terminal counts: the counter starts at 0 on entry, so the N-th edge sees N-1.
  localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(HOLD_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] GAP_LAST  = CNT_WIDTH'(STAGE_GAP - 1);
  localparam logic [CNT_WIDTH-1:0] TMO_LAST  = CNT_WIDTH'(ACK_TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [2:0]           LAST_IDX  = 3'(NUM_STAGES - 1);

  state_t                  state, state_d;
  logic [CNT_WIDTH-1:0]    cnt, cnt_d;
  logic [NUM_STAGES-1:0]   rst_n_d;
  logic [2:0]              idx_d;
  logic [2:0]              idx_inc;
  logic                    busy_d, done_d, terr_d;
  logic                    cur_ack;

  // Select the ack bit of the stage currently awaited; all other bits are don't-care.
  always_comb begin
    cur_ack = 1'b0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (i == {29'd0, stage_idx}) cur_ack = stage_ack[i];
    end
  end

  assign idx_inc = stage_idx + 3'd1;

  // Next-state and next-output logic; soft_rst_req overrides any ack or timeout on the same edge.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    rst_n_d = stage_rst_n;
    idx_d   = stage_idx;
    busy_d  = busy;
    done_d  = done;
    terr_d  = timeout_err;

    if (soft_rst_req) begin
      state_d = HOLD;
      cnt_d   = '0;
      rst_n_d = '0;
      idx_d   = 3'd0;
      busy_d  = 1'b1;
      done_d  = 1'b0;
      terr_d  = 1'b0;
    end else begin
      case (state)
        HOLD: begin
          if (cnt == HOLD_LAST) begin
            rst_n_d[0] = 1'b1;
            cnt_d      = '0;
            state_d    = WAIT_ACK;
          end else begin
            cnt_d = cnt + CNT_ONE;
          end
        end
        WAIT_ACK: begin
          if (cur_ack || (cnt == TMO_LAST)) begin
            // A forced advance is flagged only when the ack really is missing.
            if (!cur_ack) terr_d = 1'b1;
            cnt_d = '0;
            if (stage_idx == LAST_IDX) begin
              state_d = DONE;
              done_d  = 1'b1;
              busy_d  = 1'b0;
            end else begin
              state_d = GAP;
            end
          end else begin
            cnt_d = cnt + CNT_ONE;
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            idx_d   = idx_inc;
            cnt_d   = '0;
            state_d = WAIT_ACK;
            for (int i = 0; i < NUM_STAGES; i++) begin
              if (i == {29'd0, idx_inc}) rst_n_d[i] = 1'b1;
            end
          end else begin
            cnt_d = cnt + CNT_ONE;
          end
        end
        DONE: begin
          // Sequence complete: everything holds until a reset source arrives.
        end
        default: begin
          state_d = HOLD;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State and registered outputs; RST_N low restores the full reset state in one edge.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state       <= HOLD;
      cnt         <= '0;
      stage_rst_n <= '0;
      stage_idx   <= 3'd0;
      busy        <= 1'b1;
      done        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      stage_rst_n <= rst_n_d;
      stage_idx   <= idx_d;
      busy        <= busy_d;
      done        <= done_d;
      timeout_err <= terr_d;
    end
  end

endmodule

// File: tb/tb_reset_release_sequencer.sv
// Directed bench for reset_release_sequencer with default parameters (3 stages, hold 16, gap 4, timeout 64).
// Edge 0 is the last edge with RST_N low; edge k is the k-th edge after it. Outputs sampled 1 time unit after each edge.
// Observed vector packs {stage_rst_n[2:0], stage_idx[2:0], busy, done, timeout_err}.
module tb_reset_release_sequencer;

  logic       CLK;
  logic       RST_N;
  logic       soft_rst_req;
  logic [2:0] stage_ack;
  logic [2:0] stage_rst_n;
  logic [2:0] stage_idx;
  logic       busy;
  logic       done;
  logic       timeout_err;

  logic [8:0] obs;
  logic [8:0] exp_v;
  int         cur_edge;
  int         n_checks;
  int         n_pass;

  reset_release_sequencer #(
    .NUM_STAGES (3),
    .HOLD_CYCLES(16),
    .STAGE_GAP  (4),
    .ACK_TIMEOUT(64),
    .CNT_WIDTH  (8)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .soft_rst_req(soft_rst_req),
    .stage_ack   (stage_ack),
    .stage_rst_n (stage_rst_n),
    .stage_idx   (stage_idx),
    .busy        (busy),
    .done        (done),
    .timeout_err (timeout_err)
  );

  assign obs = {stage_rst_n, stage_idx, busy, done, timeout_err};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic apply_reset(input logic [2:0] ack);
    RST_N        = 1'b0;
    soft_rst_req = 1'b0;
    stage_ack    = ack;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RST_N    = 1'b1;
    cur_edge = 0;
  endtask

  task automatic adv_to(input int k);
    while (cur_edge < k) begin
      @(posedge CLK);
      #1;
      cur_edge++;
    end
  endtask

  task automatic test_reset();
    apply_reset(3'b111);
    exp_v = {3'b000, 3'd0, 1'b1, 1'b0, 1'b0};
    n_checks++;
    if (obs !== exp_v) $display("FAIL reset_state @%0d: got %b want %b", cur_edge, obs, exp_v); else n_pass++;
  endtask

  // Acks tied high: releases at 16, 21, 26; last ack sampled at 27 -> done.
  task automatic test_ack_sequence();
    adv_to(15); exp_v = {3'b000, 3'd0, 1'b1, 1'b0, 1'b0};
    n_checks++; if (obs !== exp_v) $display("FAIL seq_hold @%0d: got %b want %b", cur_edge, obs, exp_v); else n_pass++;
    adv_to(16); exp_v = {3'b001, 3'd0, 1'b1, 1'b0, 1'b0};
    n_checks++; if (obs !== exp_v) $display("FAIL seq_rel0 @%0d: got %b want %b", cur_edge, obs, exp_v); else n_pass++;
    adv_to(20); exp_v = {3'b001, 3'd0, 1'b1, 1'b0, 1'b0};
    n_checks++; if (obs !== exp_v) $display("FAIL seq_gap0 @%0d: got %b want %b", cur_edge, obs, exp_v); else n_pass++;
    adv_to(21); exp_v = {3'b011, 3'd1, 1'b1, 1'b0, 1'b0};
    n_checks++; if (obs !== exp_v) $display("FAIL seq_rel1 @%0d: got %b want %b", cur_edge, obs, exp_v); else n_pass++;
    adv_to(25); exp_v = {3'b011, 3'd1, 1'b1, 1'b0, 1'b0};
    n_checks++; if (obs !== exp_v) $display("FAIL seq_gap1 @%0d: got %b want %b", cur_edge, obs, exp_v); else n_pass++;
    adv_to(26); exp_v = {3'b111, 3'd2, 1'b1, 1'b0, 1'b0};
    n_checks++; if (obs !== exp_v) $display("FAIL seq_rel2 @%0d: got %b want %b", cur_edge, obs, exp_v); else n_pass++;
    adv_to(27); exp_v = {3'b111, 3'd2, 1'b0, 1'b1, 1'b0};
    n_checks++; if (obs !== exp_v) $display("FAIL seq_done @%0d: got %b want %b", cur_edge, obs, exp_v); else n_pass++;
    stage_ack = 3'b000;
    adv_to(40); exp_v = {3'b111, 3'd2, 1'b0, 1'b1, 1'b0};
    n_checks++; if (obs !== exp_v) $display("FAIL seq_done_hold @%0d: got %b want %b", cur_edge, obs, exp_v); else n_pass++;
  endtask

  // Stage 1 never acks: released at 21, forced at 85, stage 2 at 89, done at 90; soft pulse then clears the error.
  task automatic test_timeout();
    apply_reset(3'b101);
    adv_to(21); exp_v = {3'b011, 3'd1, 1'b1, 1'b0, 1'b0};
    n_checks++; if (obs !== exp_v) $display("FAIL tmo_rel1 @%0d: got %b want %b", cur_edge, obs, exp_v); else n_pass++;
    adv_to(84); exp_v = {3'b011, 3'd1, 1'b1, 1'b0, 1'b0};
    n_checks++; if (obs !== exp_v) $display("FAIL tmo_before @%0d: got %b want %b", cur_edge, obs, exp_v); else n_pass++;
    adv_to(85); exp_v = {3'b011, 3'd1, 1'b1, 1'b0, 1'b1};
    n_checks++; if (obs !== exp_v) $display("FAIL tmo_fire @%0d: got %b want %b", cur_edge, obs, exp_v); else n_pass++;
    adv_to(88); exp_v = {3'b011, 3'd1, 1'b1, 1'b0, 1'b1};
    n_checks++; if (obs !== exp_v) $display("FAIL tmo_gap @%0d: got %b want %b", cur_edge, obs, exp_v); else n_pass++;
    adv_to(89); exp_v = {3'b111, 3'd2, 1'b1, 1'b0, 1'b1};
    n_checks++; if (obs !== exp_v) $display("FAIL tmo_rel2 @%0d: got %b want %b", cur_edge, obs, exp_v); else n_pass++;
    adv_to(90); exp_v = {3'b111, 3'd2, 1'b0, 1'b1, 1'b1};
    n_checks++; if (obs !== exp_v) $display("FAIL tmo_done_sticky @%0d: got %b want %b", cur_edge, obs, exp_v); else n_pass++;
    soft_rst_req = 1'b1;
    adv_to(91); exp_v = {3'b000, 3'd0, 1'b1, 1'b0, 1'b0};
    n_checks++; if (obs !== exp_v) $display("FAIL tmo_soft_clear @%0d: got %b want %b", cur_edge, obs, exp_v); else n_pass++;
    soft_rst_req = 1'b0;
  endtask

  // Soft pulse at 22 while stage 1 is acked on the same edge: soft wins, hold restarts, stage 0 back at 38.
  task automatic test_soft_mid();
    apply_reset(3'b111);
    adv_to(21); soft_rst_req = 1'b1;
    adv_to(22); soft_rst_req = 1'b0;
    exp_v = {3'b000, 3'd0, 1'b1, 1'b0, 1'b0};
    n_checks++; if (obs !== exp_v) $display("FAIL soft_mid @%0d: got %b want %b", cur_edge, obs, exp_v); else n_pass++;
    adv_to(37); exp_v = {3'b000, 3'd0, 1'b1, 1'b0, 1'b0};
    n_checks++; if (obs !== exp_v) $display("FAIL soft_rehold @%0d: got %b want %b", cur_edge, obs, exp_v); else n_pass++;
    adv_to(38); exp_v = {3'b001, 3'd0, 1'b1, 1'b0, 1'b0};
    n_checks++; if (obs !== exp_v) $display("FAIL soft_rel0 @%0d: got %b want %b", cur_edge, obs, exp_v); else n_pass++;
  endtask

  // Soft pulse at 10 during hold restarts the count: release moves from 16 to 26.
  task automatic test_soft_in_hold();
    apply_reset(3'b111);
    adv_to(9); soft_rst_req = 1'b1;
    adv_to(10); soft_rst_req = 1'b0;
    adv_to(16); exp_v = {3'b000, 3'd0, 1'b1, 1'b0, 1'b0};
    n_checks++; if (obs !== exp_v) $display("FAIL hold_restart_16 @%0d: got %b want %b", cur_edge, obs, exp_v); else n_pass++;
    adv_to(25); exp_v = {3'b000, 3'd0, 1'b1, 1'b0, 1'b0};
    n_checks++; if (obs !== exp_v) $display("FAIL hold_restart_25 @%0d: got %b want %b", cur_edge, obs, exp_v); else n_pass++;
    adv_to(26); exp_v = {3'b001, 3'd0, 1'b1, 1'b0, 1'b0};
    n_checks++; if (obs !== exp_v) $display("FAIL hold_restart_rel @%0d: got %b want %b", cur_edge, obs, exp_v); else n_pass++;
  endtask

  // Ack of stage 0 and soft pulse both sampled at 18: no advance; stage 0 again at 34, stage 1 at 39.
  task automatic test_ack_and_soft();
    apply_reset(3'b000);
    adv_to(16); exp_v = {3'b001, 3'd0, 1'b1, 1'b0, 1'b0};
    n_checks++; if (obs !== exp_v) $display("FAIL acksoft_rel0 @%0d: got %b want %b", cur_edge, obs, exp_v); else n_pass++;
    adv_to(17); stage_ack = 3'b001; soft_rst_req = 1'b1;
    adv_to(18); soft_rst_req = 1'b0;
    exp_v = {3'b000, 3'd0, 1'b1, 1'b0, 1'b0};
    n_checks++; if (obs !== exp_v) $display("FAIL acksoft_win @%0d: got %b want %b", cur_edge, obs, exp_v); else n_pass++;
    adv_to(22); exp_v = {3'b000, 3'd0, 1'b1, 1'b0, 1'b0};
    n_checks++; if (obs !== exp_v) $display("FAIL acksoft_noadv @%0d: got %b want %b", cur_edge, obs, exp_v); else n_pass++;
    adv_to(34); exp_v = {3'b001, 3'd0, 1'b1, 1'b0, 1'b0};
    n_checks++; if (obs !== exp_v) $display("FAIL acksoft_rel0b @%0d: got %b want %b", cur_edge, obs, exp_v); else n_pass++;
    adv_to(39); exp_v = {3'b011, 3'd1, 1'b1, 1'b0, 1'b0};
    n_checks++; if (obs !== exp_v) $display("FAIL acksoft_rel1 @%0d: got %b want %b", cur_edge, obs, exp_v); else n_pass++;
  endtask

  // RST_N low sampled at 19 while in the gap after stage 0: full reset, hold restarts, release at 35.
  task automatic test_rst_in_gap();
    apply_reset(3'b111);
    adv_to(18); exp_v = {3'b001, 3'd0, 1'b1, 1'b0, 1'b0};
    n_checks++; if (obs !== exp_v) $display("FAIL gaprst_pre @%0d: got %b want %b", cur_edge, obs, exp_v); else n_pass++;
    RST_N = 1'b0;
    adv_to(19); RST_N = 1'b1;
    exp_v = {3'b000, 3'd0, 1'b1, 1'b0, 1'b0};
    n_checks++; if (obs !== exp_v) $display("FAIL gaprst_state @%0d: got %b want %b", cur_edge, obs, exp_v); else n_pass++;
    adv_to(34); exp_v = {3'b000, 3'd0, 1'b1, 1'b0, 1'b0};
    n_checks++; if (obs !== exp_v) $display("FAIL gaprst_hold @%0d: got %b want %b", cur_edge, obs, exp_v); else n_pass++;
    adv_to(35); exp_v = {3'b001, 3'd0, 1'b1, 1'b0, 1'b0};
    n_checks++; if (obs !== exp_v) $display("FAIL gaprst_rel0 @%0d: got %b want %b", cur_edge, obs, exp_v); else n_pass++;
  endtask

  // Only stage 2 acks: stage 0 times out at 80, stage 1 at 84 then times out at 148, stage 2 at 152, done at 153.
  task automatic test_foreign_ack();
    apply_reset(3'b100);
    adv_to(79); exp_v = {3'b001, 3'd0, 1'b1, 1'b0, 1'b0};
    n_checks++; if (obs !== exp_v) $display("FAIL foreign_ignored @%0d: got %b want %b", cur_edge, obs, exp_v); else n_pass++;
    adv_to(80); exp_v = {3'b001, 3'd0, 1'b1, 1'b0, 1'b1};
    n_checks++; if (obs !== exp_v) $display("FAIL foreign_tmo0 @%0d: got %b want %b", cur_edge, obs, exp_v); else n_pass++;
    adv_to(83); exp_v = {3'b001, 3'd0, 1'b1, 1'b0, 1'b1};
    n_checks++; if (obs !== exp_v) $display("FAIL foreign_gap @%0d: got %b want %b", cur_edge, obs, exp_v); else n_pass++;
    adv_to(84); exp_v = {3'b011, 3'd1, 1'b1, 1'b0, 1'b1};
    n_checks++; if (obs !== exp_v) $display("FAIL foreign_rel1 @%0d: got %b want %b", cur_edge, obs, exp_v); else n_pass++;
    adv_to(148); exp_v = {3'b011, 3'd1, 1'b1, 1'b0, 1'b1};
    n_checks++; if (obs !== exp_v) $display("FAIL foreign_tmo1 @%0d: got %b want %b", cur_edge, obs, exp_v); else n_pass++;
    adv_to(152); exp_v = {3'b111, 3'd2, 1'b1, 1'b0, 1'b1};
    n_checks++; if (obs !== exp_v) $display("FAIL foreign_rel2 @%0d: got %b want %b", cur_edge, obs, exp_v); else n_pass++;
    adv_to(153); exp_v = {3'b111, 3'd2, 1'b0, 1'b1, 1'b1};
    n_checks++; if (obs !== exp_v) $display("FAIL foreign_done @%0d: got %b want %b", cur_edge, obs, exp_v); else n_pass++;
  endtask

  initial begin
    RST_N        = 1'b0;
    soft_rst_req = 1'b0;
    stage_ack    = 3'b000;
    cur_edge     = 0;
    n_checks     = 0;
    n_pass       = 0;
    exp_v        = '0;

    test_reset();
    test_ack_sequence();
    test_timeout();
    test_soft_mid();
    test_soft_in_hold();
    test_ack_and_soft();
    test_rst_in_gap();
    test_foreign_ack();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
